// File: rtl/seq_muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one shift-add or
// restoring-divide step per clock, with sign fix-up on the last step.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       request, accepted when busy==0
//   op          000 MUL 001 MULH 010 MULHSU 011 MULHU
//               100 DIV 101 DIVU 110 REM  111 REMU
//   a, b        operands, sampled on accept
//   busy        high in RUN
//   done        one-cycle completion pulse
//   out, zero   registered result and (out==0)
module seq_muldiv_unit #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [N-1:0]     dv;

  // accept-side decode
  logic         sgn_a;
  logic         sgn_b;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic         res_neg;
  logic         spec_zero;
  logic         spec_ovf;
  logic         special;
  logic [N-1:0] spec_val;

  always_comb begin
    sgn_a = (op == 3'b001) || (op == 3'b010) ||
            (op == 3'b100) || (op == 3'b110);
    sgn_b = (op == 3'b001) || (op == 3'b100) ||
            (op == 3'b110);
    a_neg = sgn_a & a[N-1];
    b_neg = sgn_b & b[N-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
    // remainder follows dividend; others follow a^b
    res_neg = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    spec_zero = op[2] & (b == '0);
    spec_ovf  = op[2] & ~op[0] & (a == MIN) &
                (b == '1);
    special   = spec_zero | spec_ovf;
    spec_val  = '0;
    if (spec_zero) begin
      spec_val = op[1] ? a : '1;
    end else if (spec_ovf) begin
      spec_val = op[1] ? '0 : a;
    end
  end

  // iteration step
  logic [N:0]     sum;
  logic [N-1:0]   m_hi;
  logic [N-1:0]   m_lo;
  logic [N:0]     r_sh;
  logic [N:0]     diff;
  logic           qbit;
  logic [N-1:0]   d_hi;
  logic [N-1:0]   d_lo;
  logic [N-1:0]   nx_hi;
  logic [N-1:0]   nx_lo;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]   quo_s;
  logic [N-1:0]   rem_s;
  logic [N-1:0]   res;
  logic           last;

  always_comb begin
    // multiply: lo holds multiplier, product shifts in from the top
    sum  = {1'b0, hi} + {1'b0, dv & {N{lo[0]}}};
    m_hi = sum[N:1];
    m_lo = {sum[0], lo[N-1:1]};
    // divide: hi is remainder, lo shifts dividend out / quotient in
    r_sh = {hi, lo[N-1]};
    diff = r_sh - {1'b0, dv};
    qbit = ~diff[N];
    d_hi = qbit ? diff[N-1:0] : r_sh[N-1:0];
    d_lo = {lo[N-2:0], qbit};
    nx_hi = op_q[2] ? d_hi : m_hi;
    nx_lo = op_q[2] ? d_lo : m_lo;
    prod   = {m_hi, m_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -d_lo : d_lo;
    rem_s  = neg_q ? -d_hi : d_hi;
    unique case (op_q)
      3'b000:  res = prod_s[N-1:0];
      3'b001,
      3'b010,
      3'b011:  res = prod_s[2*N-1:N];
      3'b100,
      3'b101:  res = quo_s;
      default: res = rem_s;
    endcase
    last = (cnt == CNT_W'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dv    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      zero  <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE,
        DONE: begin
          if (start && special) begin
            state <= DONE;
            done  <= 1'b1;
            out   <= spec_val;
            zero  <= (spec_val == '0);
          end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            neg_q <= res_neg;
            hi    <= '0;
            lo    <= op[2] ? mag_a : mag_b;
            dv    <= op[2] ? mag_b : mag_a;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi  <= nx_hi;
          lo  <= nx_lo;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= res;
            zero  <= (res == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Randomized bench for seq_muldiv_unit (N=32) against an
// arithmetic reference model.
module tb_seq_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        zero;

  int n_chk;
  int n_pass;
  bit started;

  seq_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y);
    longint sx;
    longint sy;
    longint ux;
    longint uy;
    logic [63:0] p;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p  = '0;
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return x;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy;
        return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return 32'h0;
        p = sx % sy;
        return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y);
    if (!o[2]) return 1'b0;
    if (y == 0) return 1'b1;
    return !o[0] && x == 32'h8000_0000 &&
           y == 32'hFFFF_FFFF;
  endfunction

  // Runs one op; optionally drives garbage while busy and
  // optionally issues a follow-up op in the done cycle.
  task automatic do_op(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit noise,
                       input bit chain,
                       input logic [2:0] o2,
                       input logic [31:0] x2,
                       input logic [31:0] y2);
    int k;
    int nbusy;
    bit sp;
    logic [31:0] exp;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
    end
    started = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
    k = 0;
    nbusy = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        if (chain) begin
          start = 1'b1;
          op = o2;
          a = x2;
          b = y2;
          started = 1'b1;
        end else begin
          start = 1'b0;
        end
        break;
      end
      if (busy) nbusy++;
      if (noise && busy) begin
        start = 1'($urandom);
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    sp  = is_special(o, x, y);
    exp = ref_res(o, x, y);
    chk("latency", k, sp ? 1 : 33);
    chk("busy_cycles", nbusy, sp ? 0 : 32);
    chk("result", out, exp);
    chk("zero", {31'b0, zero}, {31'b0, exp == 0});
    if (!chain) begin
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    n_chk = 0;
    n_pass = 0;
    started = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #22;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFF9, 0, 0, 0, 0, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0);
    do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0);
    do_op(3'd5, 32'd100, 32'd7, 0, 0, 0, 0, 0);
    do_op(3'd7, 32'd100, 32'd7, 0, 0, 0, 0, 0);
    do_op(3'd5, 32'd5, 32'd0, 0, 0, 0, 0, 0);
    do_op(3'd7, 32'd5, 32'd0, 0, 0, 0, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

    // garbage during RUN, then back-to-back chains
    do_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 1, 0, 0, 0, 0);
    do_op(3'd4, 32'd1000, 32'd3, 1, 1, 3'd6, 32'hFFFF_FC18, 32'd7);
    do_op(3'd6, 32'hFFFF_FC18, 32'd7, 0, 1, 3'd5, 32'd9, 32'd0);
    do_op(3'd5, 32'd9, 32'd0, 0, 1, 3'd0, 32'd3, 32'd5);
    do_op(3'd0, 32'd3, 32'd5, 0, 0, 0, 0, 0);

    // reset mid-run aborts with no done
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    a = 32'd12345;
    b = 32'd678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_out", out, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    do_op(3'd0, 32'd12345, 32'd678, 0, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom);
      ra = pick();
      rb = pick();
      do_op(ro, ra, rb, 1'($urandom), 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
